// File: rtl/lsu_pkg.sv
// Shared types for the load/store unit: access size, fault codes, FSM states, request latch.
package lsu_pkg;

  typedef enum logic [1:0] {
    SZ_B = 2'd0,
    SZ_H = 2'd1,
    SZ_W = 2'd2,
    SZ_D = 2'd3
  } size_e;

  typedef enum logic [1:0] {
    FAULT_NONE     = 2'd0,
    FAULT_MISALIGN = 2'd1,
    FAULT_TIMEOUT  = 2'd2
  } fault_e;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_REQ,
    ST_WAIT_R,
    ST_DONE
  } state_e;

  typedef struct packed {
    logic  we;
    size_e size;
    logic  uns;
  } lsu_req_t;

  // Natural alignment check on the low address bits.
  function automatic logic is_misaligned(size_e size, logic [2:0] addr_lo);
    logic mis;
    case (size)
      SZ_B:    mis = 1'b0;
      SZ_H:    mis = addr_lo[0];
      SZ_W:    mis = (addr_lo[1:0] != 2'b00);
      default: mis = (addr_lo != 3'b000);
    endcase
    return mis;
  endfunction

endpackage

// File: rtl/lsu_align.sv
// Byte-lane steering: store data shift and byte enables, load extract and sign/zero extension.
module lsu_align
  import lsu_pkg::*;
#(
  parameter  int unsigned DATA_WIDTH = 32,
  localparam int unsigned NB         = DATA_WIDTH / 8,
  localparam int unsigned LW         = $clog2(NB)
) (
  input  size_e                 size,
  input  logic [LW-1:0]         lane,
  input  logic                  uns,
  input  logic [DATA_WIDTH-1:0] wdata,
  input  logic [DATA_WIDTH-1:0] rdata,
  output logic [DATA_WIDTH-1:0] st_data_c,
  output logic [NB-1:0]         byteen_c,
  output logic [DATA_WIDTH-1:0] ld_data_c
);

  logic [NB-1:0]         size_be;
  logic [DATA_WIDTH-1:0] size_mask;
  logic [DATA_WIDTH-1:0] ld_shift;
  logic                  sign;

  always_comb begin
    case (size)
      SZ_B:    size_be = NB'(1);
      SZ_H:    size_be = NB'(3);
      SZ_W:    size_be = NB'(15);
      default: size_be = '1;
    endcase
  end

  for (genvar i = 0; i < NB; i++) begin : g_mask
    assign size_mask[i*8 +: 8] = {8{size_be[i]}};
  end

  assign byteen_c  = size_be << lane;
  assign st_data_c = (wdata & size_mask) << {lane, 3'b000};
  assign ld_shift  = rdata >> {lane, 3'b000};

  // A full-width access has an all-ones mask, so extension is a no-op there.
  always_comb begin
    case (size)
      SZ_B:    sign = ld_shift[7];
      SZ_H:    sign = ld_shift[15];
      SZ_W:    sign = ld_shift[31];
      default: sign = 1'b0;
    endcase
    sign = sign & ~uns;
  end

  assign ld_data_c = (ld_shift & size_mask) | ({DATA_WIDTH{sign}} & ~size_mask);

endmodule

// File: rtl/dmem_lsu.sv
// Load/store unit: one access at a time over a req/gnt/rvalid memory port with timeout.
module dmem_lsu
  import lsu_pkg::*;
#(
  parameter  int unsigned DATA_WIDTH = 32,
  parameter  int unsigned ADDR_WIDTH = 32,
  parameter  int unsigned TIMEOUT    = 64,
  localparam int unsigned NB         = DATA_WIDTH / 8,
  localparam int unsigned LW         = $clog2(NB),
  localparam int unsigned MAW        = ADDR_WIDTH - LW
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req_valid,
  input  logic                  req_we,
  input  logic [1:0]            req_size,
  input  logic                  req_unsigned,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [DATA_WIDTH-1:0] req_wdata,
  output logic                  req_ready,
  output logic [DATA_WIDTH-1:0] rsp_rdata,
  output logic [1:0]            rsp_fault,
  output logic                  mem_req,
  output logic                  mem_we,
  output logic [MAW-1:0]        mem_addr,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  output logic [NB-1:0]         mem_byteen,
  input  logic                  mem_gnt,
  input  logic                  mem_rvalid,
  input  logic [DATA_WIDTH-1:0] mem_rdata
);

  localparam int unsigned CW = $clog2(TIMEOUT);

  state_e                state;
  lsu_req_t              lat;
  logic [LW-1:0]         lat_lane;
  logic [CW-1:0]         tmo_cnt;

  size_e                 a_size;
  logic [LW-1:0]         a_lane;
  logic                  a_uns;
  logic [DATA_WIDTH-1:0] st_data_c;
  logic [NB-1:0]         byteen_c;
  logic [DATA_WIDTH-1:0] ld_data_c;

  logic                  misalign;
  logic                  complete;
  logic                  tmo_hit;

  // Steering sees the live request while idle (store side) and the latch afterwards (load side).
  assign a_size = (state == ST_IDLE) ? size_e'(req_size) : lat.size;
  assign a_lane = (state == ST_IDLE) ? req_addr[LW-1:0] : lat_lane;
  assign a_uns  = (state == ST_IDLE) ? req_unsigned : lat.uns;

  lsu_align #(.DATA_WIDTH(DATA_WIDTH)) u_align (
    .size      (a_size),
    .lane      (a_lane),
    .uns       (a_uns),
    .wdata     (req_wdata),
    .rdata     (mem_rdata),
    .st_data_c (st_data_c),
    .byteen_c  (byteen_c),
    .ld_data_c (ld_data_c)
  );

  // Dword accesses on a 32-bit datapath are unsupported and reported as misaligned.
  assign misalign = is_misaligned(size_e'(req_size), req_addr[2:0]) ||
                    ((NB == 4) && (size_e'(req_size) == SZ_D));

  assign complete = ((state == ST_REQ) && mem_gnt && (lat.we || mem_rvalid)) ||
                    ((state == ST_WAIT_R) && mem_rvalid);
  assign tmo_hit  = (tmo_cnt == CW'(TIMEOUT - 1));

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= ST_IDLE;
      lat        <= '0;
      lat_lane   <= '0;
      tmo_cnt    <= '0;
      req_ready  <= 1'b0;
      rsp_rdata  <= '0;
      rsp_fault  <= FAULT_NONE;
      mem_req    <= 1'b0;
      mem_we     <= 1'b0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
      mem_byteen <= '0;
    end else begin
      req_ready <= 1'b0;
      rsp_rdata <= '0;
      rsp_fault <= FAULT_NONE;
      case (state)
        ST_IDLE: begin
          if (req_valid) begin
            lat      <= '{we: req_we, size: size_e'(req_size), uns: req_unsigned};
            lat_lane <= req_addr[LW-1:0];
            if (misalign) begin
              state     <= ST_DONE;
              req_ready <= 1'b1;
              rsp_fault <= FAULT_MISALIGN;
            end else begin
              state      <= ST_REQ;
              tmo_cnt    <= '0;
              mem_req    <= 1'b1;
              mem_we     <= req_we;
              mem_addr   <= req_addr[ADDR_WIDTH-1:LW];
              mem_wdata  <= st_data_c;
              mem_byteen <= byteen_c;
            end
          end
        end
        ST_REQ, ST_WAIT_R: begin
          if (complete) begin
            state     <= ST_DONE;
            req_ready <= 1'b1;
            mem_req   <= 1'b0;
            mem_we    <= 1'b0;
            if (!lat.we) rsp_rdata <= ld_data_c;
          end else if (tmo_hit) begin
            state     <= ST_DONE;
            req_ready <= 1'b1;
            rsp_fault <= FAULT_TIMEOUT;
            mem_req   <= 1'b0;
            mem_we    <= 1'b0;
          end else begin
            tmo_cnt <= tmo_cnt + CW'(1);
            if ((state == ST_REQ) && mem_gnt) begin
              state   <= ST_WAIT_R;
              mem_req <= 1'b0;
              mem_we  <= 1'b0;
            end
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dmem_lsu.sv
// Randomized self-checking bench for dmem_lsu, 32- and 64-bit instances against a behavioural model.
module tb_dmem_lsu;

  localparam int TMO = 8;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  logic        sel64, v32, v64, req_we, req_unsigned;
  logic [1:0]  req_size;
  logic [31:0] req_addr;
  logic [63:0] req_wdata;
  logic        mem_gnt, mem_rvalid;
  logic [63:0] mem_rdata;

  logic        r32_ready, r32_req, r32_we;
  logic [31:0] r32_rdata, r32_wdata;
  logic [1:0]  r32_fault;
  logic [29:0] r32_addr;
  logic [3:0]  r32_be;

  logic        r64_ready, r64_req, r64_we;
  logic [63:0] r64_rdata, r64_wdata;
  logic [1:0]  r64_fault;
  logic [28:0] r64_addr;
  logic [7:0]  r64_be;

  dmem_lsu #(.DATA_WIDTH(32), .ADDR_WIDTH(32), .TIMEOUT(TMO)) u_dut32 (
    .clk(clk), .rst(rst), .req_valid(v32), .req_we(req_we), .req_size(req_size),
    .req_unsigned(req_unsigned), .req_addr(req_addr), .req_wdata(req_wdata[31:0]),
    .req_ready(r32_ready), .rsp_rdata(r32_rdata), .rsp_fault(r32_fault),
    .mem_req(r32_req), .mem_we(r32_we), .mem_addr(r32_addr), .mem_wdata(r32_wdata),
    .mem_byteen(r32_be), .mem_gnt(mem_gnt), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata[31:0])
  );

  dmem_lsu #(.DATA_WIDTH(64), .ADDR_WIDTH(32), .TIMEOUT(TMO)) u_dut64 (
    .clk(clk), .rst(rst), .req_valid(v64), .req_we(req_we), .req_size(req_size),
    .req_unsigned(req_unsigned), .req_addr(req_addr), .req_wdata(req_wdata),
    .req_ready(r64_ready), .rsp_rdata(r64_rdata), .rsp_fault(r64_fault),
    .mem_req(r64_req), .mem_we(r64_we), .mem_addr(r64_addr), .mem_wdata(r64_wdata),
    .mem_byteen(r64_be), .mem_gnt(mem_gnt), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata)
  );

  logic        o_ready, o_req, o_we;
  logic [63:0] o_rdata, o_wdata;
  logic [1:0]  o_fault;
  logic [31:0] o_addr;
  logic [7:0]  o_be;

  always_comb begin
    if (sel64) begin
      o_ready = r64_ready; o_req = r64_req; o_we = r64_we; o_rdata = r64_rdata;
      o_wdata = r64_wdata; o_fault = r64_fault; o_addr = {3'b000, r64_addr}; o_be = r64_be;
    end else begin
      o_ready = r32_ready; o_req = r32_req; o_we = r32_we; o_rdata = {32'h0, r32_rdata};
      o_wdata = {32'h0, r32_wdata}; o_fault = r32_fault; o_addr = {2'b00, r32_addr};
      o_be = {4'h0, r32_be};
    end
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (dw=%0d t=%0t)", tag, got, exp, sel64 ? 64 : 32, $time);
    end
  endtask

  // Load result from first principles: pick the addressed bytes, then extend.
  function automatic logic [63:0] ref_load(input bit is64, input logic [1:0] size, input bit uns,
                                           input logic [31:0] addr, input logic [63:0] raw);
    int nb, nbytes, lane;
    logic [63:0] v, m;
    nb     = is64 ? 8 : 4;
    nbytes = 1 << size;
    lane   = int'(addr % nb);
    v      = raw >> (lane * 8);
    m      = (nbytes == 8) ? '1 : ((64'd1 << (nbytes * 8)) - 64'd1);
    v      = v & m;
    if (!uns && nbytes < 8 && v[nbytes*8-1]) v = v | ~m;
    if (!is64) v = v & 64'hFFFF_FFFF;
    return v;
  endfunction

  // One access: g = busy cycle carrying gnt, r = extra cycles from gnt to rvalid.
  task automatic access(input bit is64, input bit we, input logic [1:0] size, input bit uns,
                        input logic [31:0] addr, input logic [63:0] wdata, input logic [63:0] raw,
                        input int g, input int r, input bit stray);
    int nb, nbytes, lane, kc, k_exp, k_seen;
    bit mis;
    logic [63:0] exp_rdata, bm, dmask;
    logic [7:0]  exp_be;
    logic [1:0]  exp_fault;
    nb     = is64 ? 8 : 4;
    nbytes = 1 << size;
    lane   = int'(addr % nb);
    mis    = ((addr % nbytes) != 0) || (!is64 && size == 2'd3);
    exp_be = 8'(((1 << nbytes) - 1) << lane);
    dmask  = is64 ? '1 : 64'hFFFF_FFFF;
    for (int i = 0; i < 8; i++) bm[i*8 +: 8] = {8{exp_be[i]}};
    kc = we ? g : g + r;
    if (mis) begin
      k_exp = 0; exp_fault = 2'd1; exp_rdata = '0;
    end else if (kc <= TMO - 1) begin
      k_exp = kc + 1; exp_fault = 2'd0;
      exp_rdata = we ? 64'h0 : ref_load(is64, size, uns, addr, raw);
    end else begin
      k_exp = TMO; exp_fault = 2'd2; exp_rdata = '0;
    end

    sel64 = is64; v32 = !is64; v64 = is64;
    req_we = we; req_size = size; req_unsigned = uns; req_addr = addr; req_wdata = wdata;
    mem_gnt = stray; mem_rvalid = stray; mem_rdata = {$urandom, $urandom};
    @(posedge clk); @(negedge clk);

    k_seen = -1;
    for (int k = 0; k < 40; k++) begin
      if (o_ready) begin
        k_seen = k;
        break;
      end
      check("mem_req", 64'(o_req), 64'(k <= g));
      if (k == 0) begin
        check("mem_we", 64'(o_we), 64'(we));
        check("mem_addr", 64'(o_addr), 64'(addr >> (is64 ? 3 : 2)));
        check("mem_byteen", 64'(o_be), 64'(exp_be));
        check("mem_wdata", o_wdata & bm, (wdata << (lane * 8)) & bm & dmask);
      end
      mem_gnt    = (k == g);
      mem_rvalid = !we && (k == g + r);
      mem_rdata  = mem_rvalid ? raw : {$urandom, $urandom};
      @(posedge clk); @(negedge clk);
    end

    check("ready_latency", 64'(k_seen), 64'(k_exp));
    if (k_seen >= 0) begin
      check("rsp_fault", 64'(o_fault), 64'(exp_fault));
      check("rsp_rdata", o_rdata, exp_rdata);
      check("mem_req_done", 64'(o_req), 64'd0);
    end

    // A late response after a timeout must be ignored.
    v32 = 1'b0; v64 = 1'b0; mem_gnt = 1'b0;
    mem_rvalid = (exp_fault == 2'd2); mem_rdata = {$urandom, $urandom};
    @(posedge clk); @(negedge clk);
    check("ready_pulse", 64'(o_ready), 64'd0);
    check("rdata_idle", o_rdata, 64'd0);
    mem_rvalid = 1'b0;
  endtask

  task automatic reset_mid(input bit is64);
    sel64 = is64; v32 = !is64; v64 = is64;
    req_we = 1'b0; req_size = 2'd2; req_unsigned = 1'b0; req_addr = 32'h40;
    mem_gnt = 1'b0; mem_rvalid = 1'b0;
    @(posedge clk); @(negedge clk);
    mem_gnt = 1'b1;
    @(posedge clk); @(negedge clk);
    mem_gnt = 1'b0;
    check("wait_r_req", 64'(o_req), 64'd0);
    check("wait_r_ready", 64'(o_ready), 64'd0);
    rst = 1'b1; v32 = 1'b0; v64 = 1'b0;
    @(posedge clk); @(negedge clk);
    rst = 1'b0;
    check("rst_mid_req", 64'(o_req), 64'd0);
    check("rst_mid_ready", 64'(o_ready), 64'd0);
    check("rst_mid_addr", 64'(o_addr), 64'd0);
    check("rst_mid_byteen", 64'(o_be), 64'd0);
    mem_rvalid = 1'b1; mem_rdata = {$urandom, $urandom};
    repeat (2) begin
      @(posedge clk); @(negedge clk);
      check("rst_no_ready", 64'(o_ready), 64'd0);
    end
    mem_rvalid = 1'b0;
  endtask

  bit          t_is64, t_we, t_uns, t_stray;
  logic [1:0]  t_size;
  logic [31:0] t_addr;
  logic [63:0] t_wdata, t_raw;
  int          t_g, t_r;

  initial begin
    rst = 1'b1; sel64 = 1'b0; v32 = 1'b0; v64 = 1'b0;
    req_we = 1'b0; req_size = 2'd0; req_unsigned = 1'b0; req_addr = '0; req_wdata = '0;
    mem_gnt = 1'b0; mem_rvalid = 1'b0; mem_rdata = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    for (int s = 0; s < 2; s++) begin
      sel64 = (s == 1);
      #1;
      check("rst_ready", 64'(o_ready), 64'd0);
      check("rst_rdata", o_rdata, 64'd0);
      check("rst_fault", 64'(o_fault), 64'd0);
      check("rst_mem_req", 64'(o_req), 64'd0);
      check("rst_mem_we", 64'(o_we), 64'd0);
      check("rst_mem_addr", 64'(o_addr), 64'd0);
      check("rst_mem_wdata", o_wdata, 64'd0);
      check("rst_mem_byteen", 64'(o_be), 64'd0);
    end
    @(negedge clk);
    rst = 1'b0;

    access(1'b0, 1'b1, 2'd2, 1'b0, 32'h104, 64'hDEADBEEF, 64'h0, 0, 0, 1'b0);
    access(1'b0, 1'b0, 2'd0, 1'b0, 32'h103, 64'h0, 64'h80112233, 0, 3, 1'b0);
    access(1'b0, 1'b0, 2'd0, 1'b1, 32'h103, 64'h0, 64'h80112233, 0, 3, 1'b0);
    access(1'b0, 1'b1, 2'd1, 1'b0, 32'h22, 64'h1234, 64'h0, 1, 0, 1'b0);
    access(1'b0, 1'b0, 2'd1, 1'b0, 32'h21, 64'h0, 64'h0, 0, 0, 1'b0);
    access(1'b0, 1'b0, 2'd2, 1'b0, 32'h200, 64'h0, 64'h11111111, 0, 100, 1'b0);
    access(1'b0, 1'b0, 2'd2, 1'b0, 32'h204, 64'h0, 64'hCAFEF00D, 0, 0, 1'b1);
    access(1'b0, 1'b0, 2'd1, 1'b0, 32'h300, 64'h0, 64'h00008001, 7, 0, 1'b0);
    reset_mid(1'b0);
    access(1'b0, 1'b1, 2'd2, 1'b0, 32'h80, 64'h0BADF00D, 64'h0, 0, 0, 1'b0);
    access(1'b1, 1'b0, 2'd2, 1'b0, 32'h0C, 64'h0, 64'h80000001_5A5A5A5A, 1, 1, 1'b0);
    access(1'b1, 1'b0, 2'd3, 1'b0, 32'h0C, 64'h0, 64'h0, 0, 0, 1'b0);
    access(1'b1, 1'b0, 2'd3, 1'b0, 32'h10, 64'h0, 64'h89ABCDEF_01234567, 0, 0, 1'b0);
    reset_mid(1'b1);
    access(1'b1, 1'b1, 2'd0, 1'b0, 32'h1005, 64'hA5, 64'h0, 2, 0, 1'b0);

    for (int i = 0; i < 300; i++) begin
      t_is64  = 1'($urandom_range(0, 1));
      t_we    = 1'($urandom_range(0, 1));
      t_uns   = 1'($urandom_range(0, 1));
      t_stray = 1'($urandom_range(0, 1));
      t_size  = t_is64 ? 2'($urandom_range(0, 3)) : 2'($urandom_range(0, 2));
      t_addr  = $urandom;
      if ($urandom_range(0, 3) != 0) t_addr = t_addr & ~((32'd1 << t_size) - 32'd1);
      t_wdata = {$urandom, $urandom};
      t_raw   = {$urandom, $urandom};
      t_g     = ($urandom_range(0, 7) == 0) ? 9 : int'($urandom_range(0, 3));
      t_r     = ($urandom_range(0, 7) == 0) ? 9 : int'($urandom_range(0, 3));
      access(t_is64, t_we, t_size, t_uns, t_addr, t_wdata, t_raw, t_g, t_r, t_stray);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
